// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: access size encoding, FSM states, grant owner.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    MSize_8bits  = 3'd0,
    MSize_16bits = 3'd1,
    MSize_32bits = 3'd2,
    MSize_64bits = 3'd3
  } MemSizeType;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (fetch I, data D) and memory-side handshakes of the arbiter in one bundle.
// slave is the arbiter's view; master is the view of the pipeline stages plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) ();
  import mem_port_arbiter_pkg::*;

  logic              flush;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [INST_W-1:0] i_data;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic              d_write;
  MemSizeType        d_size;
  logic [7:0]        d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic              m_write;
  MemSizeType        m_size;
  logic [7:0]        m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;

  modport slave (
    input  flush, i_valid, i_addr, d_valid, d_addr, d_write, d_size, d_strobe, d_wdata,
           m_ready, m_rdata,
    output i_ready, i_data, d_ready, d_rdata,
           m_valid, m_addr, m_write, m_size, m_strobe, m_wdata, busy
  );

  modport master (
    output flush, i_valid, i_addr, d_valid, d_addr, d_write, d_size, d_strobe, d_wdata,
           m_ready, m_rdata,
    input  i_ready, i_data, d_ready, d_rdata,
           m_valid, m_addr, m_write, m_size, m_strobe, m_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Round-robin pick between eligible fetch and data requesters; purely combinational.
// On contention the requester not served last wins.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_elig,
  input  logic       d_elig,
  input  arb_grant_t last_grant,
  output logic       grant_valid,
  output arb_grant_t grant
);

  always_comb begin
    grant_valid = i_elig || d_elig;
    grant       = GRANT_I;
    if (i_elig && d_elig) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_elig) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D); one transaction in flight, stale fetches dropped.
// m_valid one cycle after grant, ready pulse one cycle after m_ready; requesters wait until sampled in IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    MemSizeType        size;
    logic [7:0]        strobe;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  arb_state_t        state, state_nxt;
  arb_grant_t        last_grant, grant;
  logic              grant_valid, abort, i_elig, d_elig;
  mem_req_t          req_q, i_req, d_req;
  logic              i_ready_q, d_ready_q;
  logic [INST_W-1:0] i_data_q;
  logic [DATA_W-1:0] d_rdata_q;

  // A redirect in the same cycle makes the fetch address stale, so it may not win.
  assign i_elig = bus.i_valid && !bus.flush;
  assign d_elig = bus.d_valid;

  mem_arb_pick u_pick (
    .i_elig      (i_elig),
    .d_elig      (d_elig),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    i_req        = '0;
    i_req.addr   = bus.i_addr;
    i_req.size   = MSize_32bits;
    d_req.addr   = bus.d_addr;
    d_req.write  = bus.d_write;
    d_req.size   = bus.d_size;
    d_req.strobe = bus.d_strobe;
    d_req.wdata  = bus.d_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) state_nxt = (grant == GRANT_D) ? ARB_BUSY_D : ARB_BUSY_I;
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus.m_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_I;
      abort      <= 1'b0;
      req_q      <= '0;
      i_ready_q  <= 1'b0;
      i_data_q   <= '0;
      d_ready_q  <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant;
            req_q      <= (grant == GRANT_D) ? d_req : i_req;
          end
        end
        ARB_BUSY_I: begin
          // The bus transaction always completes; a flushed fetch just loses its ready pulse.
          if (bus.m_ready) begin
            i_ready_q <= !(abort || bus.flush);
            i_data_q  <= bus.m_rdata[INST_W-1:0];
            abort     <= 1'b0;
          end else if (bus.flush) begin
            abort <= 1'b1;
          end
        end
        ARB_BUSY_D: begin
          if (bus.m_ready) begin
            d_ready_q <= 1'b1;
            d_rdata_q <= bus.m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != ARB_IDLE);
    bus.m_valid  = (state != ARB_IDLE);
    bus.m_addr   = req_q.addr;
    bus.m_write  = req_q.write;
    bus.m_size   = req_q.size;
    bus.m_strobe = req_q.strobe;
    bus.m_wdata  = req_q.wdata;
    bus.i_ready  = i_ready_q;
    bus.i_data   = i_data_q;
    bus.d_ready  = d_ready_q;
    bus.d_rdata  = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences, random traffic vs a transaction model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        iv, dv, fl;
    logic [63:0] iaddr, daddr;
    logic        dw;
    logic [2:0]  dsize;
    logic [7:0]  dstrb;
    logic [63:0] dwdata;
    int          dly;
    logic [63:0] rdata;
    logic        e_grant;
    logic [63:0] e_addr;
    logic        e_write;
    logic [2:0]  e_size;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic        e_ir;
    logic [31:0] e_idata;
    logic        e_dr;
    logic [63:0] e_drdata;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.i_valid = 0; bus.i_addr = '0;
    bus.d_valid = 0; bus.d_addr = '0; bus.d_write = 0; bus.d_size = MSize_8bits;
    bus.d_strobe = '0; bus.d_wdata = '0; bus.m_ready = 0; bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ir_cnt, dr_cnt;
    do_reset();
    ir_cnt = 0; dr_cnt = 0;
    bus.i_valid = v.iv; bus.i_addr = v.iaddr; bus.flush = v.fl;
    bus.d_valid = v.dv; bus.d_addr = v.daddr; bus.d_write = v.dw;
    bus.d_size = MemSizeType'(v.dsize); bus.d_strobe = v.dstrb; bus.d_wdata = v.dwdata;
    bus.m_rdata = v.rdata;
    for (int c = 1; c <= v.dly + 3; c++) begin
      step();
      ir_cnt += int'(bus.i_ready);
      dr_cnt += int'(bus.d_ready);
      if (c <= v.dly + 1) begin
        chk($sformatf("v%0d_c%0d_m_valid", idx, c), 64'(bus.m_valid), 64'(v.e_grant));
        if (v.e_grant) begin
          chk($sformatf("v%0d_c%0d_m_addr", idx, c), bus.m_addr, v.e_addr);
          chk($sformatf("v%0d_c%0d_m_write", idx, c), 64'(bus.m_write), 64'(v.e_write));
          chk($sformatf("v%0d_c%0d_m_size", idx, c), 64'(bus.m_size), 64'(v.e_size));
          chk($sformatf("v%0d_c%0d_m_strobe", idx, c), 64'(bus.m_strobe), 64'(v.e_strb));
          chk($sformatf("v%0d_c%0d_m_wdata", idx, c), bus.m_wdata, v.e_wdata);
        end
      end
      if (c == v.dly + 2) begin
        chk($sformatf("v%0d_i_ready", idx), 64'(bus.i_ready), 64'(v.e_ir));
        chk($sformatf("v%0d_d_ready", idx), 64'(bus.d_ready), 64'(v.e_dr));
        if (v.e_ir) chk($sformatf("v%0d_i_data", idx), 64'(bus.i_data), 64'(v.e_idata));
        if (v.e_dr) chk($sformatf("v%0d_d_rdata", idx), bus.d_rdata, v.e_drdata);
        idle_inputs();
      end
      bus.m_ready = (c == v.dly + 1);
    end
    chk($sformatf("v%0d_i_pulses", idx), 64'(ir_cnt), 64'(v.e_ir));
    chk($sformatf("v%0d_d_pulses", idx), 64'(dr_cnt), 64'(v.e_dr));
  endtask

  // Transaction-level reference for the random phase.
  typedef struct {
    bit          active;
    bit          is_d;
    bit          stale;
    logic [63:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } txn_t;

  initial begin
    txn_t        cur;
    bit          served_d_last, e_ir, e_dr, i_pend, d_pend, ie, de, take_d, prev_mv, prev_ir, prev_dr;
    logic [31:0] e_idata;
    logic [63:0] e_drdata;
    arb_grant_t  order [$];
    int          age, i_pulses, d_pulses, dbl, d_first, i_first_mv, cnt;

    // ---------------- table ----------------
    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // fetch only
    vecs[0].iv = 1; vecs[0].iaddr = 64'h8000_0000; vecs[0].dly = 1; vecs[0].rdata = 64'h0000_0013_0010_0093;
    vecs[0].e_grant = 1; vecs[0].e_addr = 64'h8000_0000; vecs[0].e_size = 3'd2;
    vecs[0].e_ir = 1; vecs[0].e_idata = 32'h0010_0093;
    // contention after reset: D first
    vecs[1].iv = 1; vecs[1].iaddr = 64'h8000_0040; vecs[1].dv = 1; vecs[1].daddr = 64'h1000;
    vecs[1].dsize = 3'd3; vecs[1].dstrb = 8'hFF; vecs[1].dwdata = 64'h55; vecs[1].dly = 0;
    vecs[1].rdata = 64'h1122_3344_5566_7788;
    vecs[1].e_grant = 1; vecs[1].e_addr = 64'h1000; vecs[1].e_size = 3'd3; vecs[1].e_strb = 8'hFF;
    vecs[1].e_wdata = 64'h55; vecs[1].e_dr = 1; vecs[1].e_drdata = 64'h1122_3344_5566_7788;
    // store with slow memory
    vecs[2].dv = 1; vecs[2].daddr = 64'h2000; vecs[2].dw = 1; vecs[2].dsize = 3'd2; vecs[2].dstrb = 8'h0F;
    vecs[2].dwdata = 64'hDEAD_BEEF; vecs[2].dly = 5; vecs[2].rdata = 64'hCAFE_F00D_0000_0001;
    vecs[2].e_grant = 1; vecs[2].e_addr = 64'h2000; vecs[2].e_write = 1; vecs[2].e_size = 3'd2;
    vecs[2].e_strb = 8'h0F; vecs[2].e_wdata = 64'hDEAD_BEEF; vecs[2].e_dr = 1; vecs[2].e_drdata = 64'hCAFE_F00D_0000_0001;
    // flush blocks fetch grant; m_ready in IDLE ignored
    vecs[3].iv = 1; vecs[3].fl = 1; vecs[3].iaddr = 64'h8000_0080; vecs[3].dly = 1; vecs[3].rdata = 64'h77;
    // flush does not affect D, and I loses under flush
    vecs[4].iv = 1; vecs[4].dv = 1; vecs[4].fl = 1; vecs[4].iaddr = 64'h8000_00C0; vecs[4].daddr = 64'h4008;
    vecs[4].dsize = 3'd1; vecs[4].dstrb = 8'h03; vecs[4].dly = 2; vecs[4].rdata = 64'hABCD;
    vecs[4].e_grant = 1; vecs[4].e_addr = 64'h4008; vecs[4].e_size = 3'd1; vecs[4].e_strb = 8'h03;
    vecs[4].e_dr = 1; vecs[4].e_drdata = 64'hABCD;
    // nothing requested
    vecs[5].dly = 0; vecs[5].rdata = 64'h99;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd0);
    chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
    chk("rst_m_addr", bus.m_addr, 64'd0);
    chk("rst_m_strobe", 64'(bus.m_strobe), 64'd0);
    chk("rst_i_data", 64'(bus.i_data), 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ---------------- round-robin ----------------
    do_reset();
    bus.i_valid = 1; bus.i_addr = 64'h8000_0000;
    bus.d_valid = 1; bus.d_addr = 64'h1000;
    prev_mv = 0; prev_ir = 0; prev_dr = 0; age = 0;
    i_pulses = 0; d_pulses = 0; dbl = 0; d_first = -1; i_first_mv = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus.m_valid && !prev_mv) begin
        order.push_back((bus.m_addr == 64'h1000) ? GRANT_D : GRANT_I);
        if (bus.m_addr != 64'h1000 && i_first_mv < 0) i_first_mv = c;
      end
      if (bus.d_ready && d_first < 0) d_first = c;
      if ((bus.i_ready && prev_ir) || (bus.d_ready && prev_dr)) dbl++;
      i_pulses += int'(bus.i_ready);
      d_pulses += int'(bus.d_ready);
      age = bus.m_valid ? age + 1 : 0;
      bus.m_ready = (age == 2);
      prev_mv = bus.m_valid; prev_ir = bus.i_ready; prev_dr = bus.d_ready;
    end
    chk("rr_grant_count", 64'(order.size()), 64'd4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk($sformatf("rr_grant%0d", k), 64'(order[k]), (k % 2 == 0) ? 64'(GRANT_D) : 64'(GRANT_I));
    chk("rr_i_after_d_ready", 64'(i_first_mv), 64'(d_first + 1));
    chk("rr_i_pulses", 64'(i_pulses), 64'd2);
    chk("rr_d_pulses", 64'(d_pulses), 64'd2);
    chk("rr_long_pulses", 64'(dbl), 64'd0);

    // ---------------- flush in flight ----------------
    do_reset();
    cnt = 0;
    bus.i_valid = 1; bus.i_addr = 64'h8000_0000;
    step();                                            // c1
    chk("fl_m_valid_c1", 64'(bus.m_valid), 64'd1);
    step();                                            // c2
    bus.flush = 1; bus.i_valid = 0;
    step();                                            // c3
    bus.flush = 0;
    chk("fl_busy_c3", 64'(bus.busy), 64'd1);
    step();                                            // c4
    chk("fl_m_valid_c4", 64'(bus.m_valid), 64'd1);
    bus.m_ready = 1; bus.m_rdata = 64'h1111_2222;
    step();                                            // c5
    bus.m_ready = 0;
    cnt += int'(bus.i_ready);
    chk("fl_done_m_valid", 64'(bus.m_valid), 64'd0);
    chk("fl_i_ready_suppressed", 64'(bus.i_ready), 64'd0);
    bus.i_valid = 1; bus.i_addr = 64'h8000_0100;
    step();                                            // c6
    cnt += int'(bus.i_ready);
    chk("fl_new_m_addr", bus.m_addr, 64'h8000_0100);
    bus.m_ready = 1; bus.m_rdata = 64'h0000_0000_0000_0513;
    step();                                            // c7
    bus.m_ready = 0; bus.i_valid = 0;
    cnt += int'(bus.i_ready);
    chk("fl_new_i_ready", 64'(bus.i_ready), 64'd1);
    chk("fl_new_i_data", 64'(bus.i_data), 64'h513);
    step();                                            // c8
    cnt += int'(bus.i_ready);
    chk("fl_i_pulses_total", 64'(cnt), 64'd1);

    // flush coincident with m_ready
    do_reset();
    bus.i_valid = 1; bus.i_addr = 64'h8000_0200;
    step();
    bus.i_valid = 0; bus.flush = 1; bus.m_ready = 1; bus.m_rdata = 64'h33;
    step();
    bus.flush = 0; bus.m_ready = 0;
    chk("flr_i_ready", 64'(bus.i_ready), 64'd0);
    chk("flr_busy", 64'(bus.busy), 64'd0);

    // ---------------- async reset in BUSY_D ----------------
    do_reset();
    bus.d_valid = 1; bus.d_addr = 64'h3000;
    step();
    chk("ar_m_valid_before", 64'(bus.m_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_m_valid_async", 64'(bus.m_valid), 64'd0);
    chk("ar_busy_async", 64'(bus.busy), 64'd0);
    bus.d_valid = 0;
    bus.m_ready = 1;
    step();
    chk("ar_no_d_ready", 64'(bus.d_ready), 64'd0);
    bus.m_ready = 0;
    reset = 1'b0;
    step();
    chk("ar_idle_after", 64'(bus.busy), 64'd0);
    chk("ar_no_d_ready_after", 64'(bus.d_ready), 64'd0);
    bus.i_valid = 1; bus.i_addr = 64'h8000_0300;
    bus.d_valid = 1; bus.d_addr = 64'h3008;
    step();
    chk("ar_d_first", bus.m_addr, 64'h3008);

    // ---------------- random traffic ----------------
    do_reset();
    cur = '{default: 0};
    served_d_last = 0; e_ir = 0; e_dr = 0; e_idata = '0; e_drdata = '0;
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      chk("rnd_m_valid", 64'(bus.m_valid), 64'(cur.active));
      chk("rnd_busy", 64'(bus.busy), 64'(cur.active));
      if (cur.active) begin
        chk("rnd_m_addr", bus.m_addr, cur.addr);
        chk("rnd_m_write", 64'(bus.m_write), 64'(cur.write));
        chk("rnd_m_size", 64'(bus.m_size), 64'(cur.size));
        chk("rnd_m_strobe", 64'(bus.m_strobe), 64'(cur.strb));
        chk("rnd_m_wdata", bus.m_wdata, cur.wdata);
      end
      chk("rnd_i_ready", 64'(bus.i_ready), 64'(e_ir));
      if (e_ir) chk("rnd_i_data", 64'(bus.i_data), 64'(e_idata));
      chk("rnd_d_ready", 64'(bus.d_ready), 64'(e_dr));
      if (e_dr) chk("rnd_d_rdata", bus.d_rdata, e_drdata);

      // requesters: fetch drops its request on its ready or a redirect, data only on its ready
      if (bus.i_ready || bus.flush) i_pend = 0;
      if (bus.d_ready) d_pend = 0;
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; bus.i_addr = {$urandom, $urandom};
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; bus.d_addr = {$urandom, $urandom}; bus.d_write = 1'($urandom_range(0, 1));
        bus.d_size = MemSizeType'(3'($urandom_range(0, 3))); bus.d_strobe = 8'($urandom);
        bus.d_wdata = {$urandom, $urandom};
      end
      bus.i_valid = i_pend;
      bus.d_valid = d_pend;
      bus.flush   = ($urandom_range(0, 7) == 0);
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.m_rdata = {$urandom, $urandom};

      // model: what the next cycle must show
      e_ir = 0; e_dr = 0;
      if (!cur.active) begin
        ie = bus.i_valid && !bus.flush;
        de = bus.d_valid;
        if (ie || de) begin
          take_d = de && (!ie || !served_d_last);
          served_d_last = take_d;
          cur.active = 1; cur.is_d = take_d; cur.stale = 0;
          if (take_d) begin
            cur.addr = bus.d_addr; cur.write = bus.d_write; cur.size = 3'(bus.d_size);
            cur.strb = bus.d_strobe; cur.wdata = bus.d_wdata;
          end else begin
            cur.addr = bus.i_addr; cur.write = 0; cur.size = 3'd2; cur.strb = '0; cur.wdata = '0;
          end
        end
      end else begin
        if (!cur.is_d && bus.flush) cur.stale = 1;
        if (bus.m_ready) begin
          if (cur.is_d) begin
            e_dr = 1; e_drdata = bus.m_rdata;
          end else begin
            e_ir = !cur.stale; e_idata = bus.m_rdata[31:0];
          end
          cur.active = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
